// File: rtl/shift_counter_nbit.sv
// Johnson / ring shift-register counter with parallel load, decoded index, wrap pulse and illegal flag.
// Optional macro SELF_CORRECT_EN: an enabled step from an illegal pattern reloads the mode seed.
module shift_counter_nbit #(
  parameter  int WIDTH = 4,
  localparam int IW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IW-1:0]    idx,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IW:0]      TWO_W = (IW+1)'(2*WIDTH);
  localparam logic [IW-1:0]    JMAX  = IW'(2*WIDTH-1);
  localparam logic [IW-1:0]    RMAX  = IW'(WIDTH-1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] shifted;
  logic [IW-1:0]    idx_cur, idx_nxt, max_idx;
  logic             illegal_cur, correct;

  // Johnson: ones run from bit0 upward, or zeros run from bit0 upward. Ring: one-hot.
  function automatic logic legal_f(input logic [WIDTH-1:0] v, input logic m);
    logic [WIDTH-1:0] inv;
    logic             jl, rl;
    inv = ~v;
    jl  = ((v & (v + ONE)) == '0) || ((inv & (inv + ONE)) == '0);
    rl  = (v != '0) && ((v & (v - ONE)) == '0);
    return m ? rl : jl;
  endfunction

  function automatic logic [IW-1:0] decode_f(input logic [WIDTH-1:0] v, input logic m);
    logic [IW:0]   cnt, jidx;
    logic [IW-1:0] ridx;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + {{IW{1'b0}}, v[i]};
    jidx = v[WIDTH-1] ? (TWO_W - cnt) : cnt;
    ridx = '0;
    for (int i = WIDTH-1; i >= 0; i--) if (v[i]) ridx = IW'(i);
    if (!legal_f(v, m)) return '0;
    return m ? ridx : jidx[IW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_f(input logic [WIDTH-1:0] v,
                                               input logic m, input logic d);
    logic fb_l, fb_r;
    fb_l = m ? v[WIDTH-1] : ~v[WIDTH-1];
    fb_r = m ? v[0]       : ~v[0];
    return d ? {fb_r, v[WIDTH-1:1]} : {v[WIDTH-2:0], fb_l};
  endfunction

`ifdef SELF_CORRECT_EN
  assign correct = illegal_cur;
`else
  assign correct = 1'b0;
`endif

  assign illegal_cur = !legal_f(q_q, mode);
  assign idx_cur     = decode_f(q_q, mode);

  always_comb begin
    shifted = shift_f(q_q, mode, dir);
    idx_nxt = decode_f(shifted, mode);
    max_idx = mode ? RMAX : JMAX;
    q_d     = q_q;
    wrap_d  = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (correct) begin
        q_d = mode ? ONE : '0;
      end else if (mode && (q_q == '0)) begin
        q_d = ONE;
      end else begin
        q_d    = shifted;
        // Only a legal step crossing the max/0 boundary in the travel direction wraps.
        wrap_d = !illegal_cur &&
                 (dir ? ((idx_cur == '0) && (idx_nxt == max_idx))
                      : ((idx_cur == max_idx) && (idx_nxt == '0)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q       = q_q;
  assign wrap    = wrap_q;
  assign idx     = idx_cur;
  assign illegal = illegal_cur;

endmodule

// File: doc/shift_counter_nbit.md
Name: shift_counter_nbit

Overview:
Parametrised shift-register counter built from a WIDTH-bit register chain. It runs as a Johnson (twisted-ring, 2*WIDTH states) or a ring (one-hot, WIDTH states) counter. Mode and direction are selected at run time. It also provides synchronous parallel load, a decoded state index, a wrap pulse and an illegal-state flag. It is the general counter primitive for sequencers and phase generators in the counter library.

Parameters:
WIDTH, 4, number of register stages (>=2).
IW, $clog2(2*WIDTH), localparam: width of idx.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
en  input  1  step enable.
mode  input  1  0 = Johnson, 1 = ring.
dir  input  1  0 = shift left (idx up), 1 = shift right (idx down).
load  input  1  synchronous parallel load, priority over en.
load_val  input  WIDTH  value written on load.
q  output  WIDTH  counter state (registered).
idx  output  IW  decoded state index (combinational from q and mode).
wrap  output  1  registered one-cycle terminal pulse.
illegal  output  1  q not a legal pattern for current mode (combinational).

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-count):
  - q=0 and wrap=0 immediately.
  - Held while rst=0.
  - Counting resumes on the first rising clk edge after rst returns high.
- Priority per rising edge: load > en > hold.
- load=1: q<=load_val, wrap<=0. Loaded value is not validated; illegal reflects it.
- en=1, load=0, Johnson:
  - dir=0: q<={q[W-2:0], ~q[W-1]}.
  - dir=1: q<={~q[0], q[W-1:1]}.
- en=1, load=0, ring:
  - q==0 (seed case): q<=1. Not counted as a step; wrap<=0.
  - Otherwise dir=0: q<={q[W-2:0], q[W-1]}; dir=1: q<={q[0], q[W-1:1]}.
- en=0, load=0: q holds; wrap<=0.
- Legal patterns:
  - Johnson: contiguous ones anchored at bit0 or at bit W-1, including all-0 and all-1.
  - Ring: exactly one bit set.
  - illegal=1 otherwise. Ring q==0 is illegal.
- idx decoding:
  - Johnson: q[W-1]==0 gives popcount(q); else 2W - popcount(q).
  - Ring: position of the lowest set bit.
  - idx=0 when illegal=1.
- wrap=1 for exactly one cycle after a normal step that takes idx from max to 0 (dir=0) or from 0 to max (dir=1).
  - Max is 2W-1 in Johnson mode, W-1 in ring mode.
  - Never asserted after a load, seed or correction step.
- Mode/dir changes:
  - Take effect on the next edge. q is reinterpreted under the new mode with no reset.
  - illegal and idx update combinationally.
- Simultaneous load and en: load wins; no step occurs.
- Latency: q, wrap one cycle after the sampling edge; idx, illegal zero-cycle from q.

Optional Feature:
SELF_CORRECT_EN
- Defined:
  - When en=1, load=0 and illegal=1, the next q is the mode seed (Johnson 0, ring 1) instead of the shift result.
  - wrap<=0 on that step.
  - Recovery takes one enabled cycle.
- Undefined:
  - Illegal patterns shift under the normal rules and may circulate indefinitely.
  - Only load or reset recover them; the ring seed rule still applies.

Test Plan:
1. W=4, rst pulse low mid-count at arbitrary time (not on clk edge) -> q=0000, wrap=0 without waiting for clk; hold rst low 3 cycles -> q stays 0000.
2. Johnson up: mode=0, dir=0, en=1 for 8 cycles from reset -> q=0001,0011,0111,1111,1110,1100,1000,0000; idx=1..7,0; wrap=1 only in the cycle after the 8th step.
3. Ring down: mode=1, dir=1, en=1 from reset -> first edge q=0001 (seed, wrap=0), then 1000,0100,0010,0001; idx=3,2,1,0; wrap=1 after the 0001->1000 step.
4. Load priority: load=1, en=1, load_val=0110, mode=0 -> q=0110, illegal=1, idx=0, wrap=0. Next en step: with SELF_CORRECT_EN q=0000, illegal=0; without it q=1101, illegal=1.
5. Hold and mode switch: q=0011 Johnson, en=0 for 4 cycles -> q stays 0011, wrap=0. Set mode=1 -> illegal=1 immediately; set load_val=0100, load=1 -> q=0100, idx=2, illegal=0.
